// File: rtl/game_pkg.sv
// Shared Pika volleyball definitions: match state encodings, playfield geometry
// and the ball/ground/net tests used by the match sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PLAY  = 2'd2,
    ST_END   = 2'd3
  } game_state_t;

  localparam int GROUND_Y = 220;
  localparam int BALL_W   = 30;
  localparam int BALL_H   = 30;
  localparam int NET_X    = 160;
  localparam int NET_W    = 6;

  // Evaluated one bit wider than the coordinates so a ball near the
  // bottom of the 12-bit range cannot wrap past the ground line.
  function automatic logic ball_grounded(input logic [11:0] ball_y,
                                         input int ball_h,
                                         input int ground_y);
    logic [12:0] bottom;
    bottom = {1'b0, ball_y} + 13'(ball_h);
    return bottom >= 13'(ground_y);
  endfunction

  // True when the ball centre lies strictly left of the net centre;
  // a centre exactly on the split belongs to the right half.
  function automatic logic lands_left(input logic [11:0] ball_x,
                                      input int ball_w,
                                      input int net_x,
                                      input int net_w);
    logic [12:0] centre;
    centre = {1'b0, ball_x} + 13'(ball_w / 2);
    return centre < 13'(net_x + net_w / 2);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-flop rising-edge detector for a synchronous, debounced level.
module rise_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= level;
    end
  end

  assign rise = level & ~prev_reg;

endmodule

// File: rtl/game_ctrl.sv
// Pika volleyball match sequencer: serve delay, ground detection, scoring and
// match end, driving the ball engine's Game_state / who_win inputs.
module game_ctrl #(
  parameter int WIN_SCORE = 5,
  parameter int DROP_WAIT = 50_000_000,
  parameter int GROUND_Y  = game_pkg::GROUND_Y,
  parameter int BALL_H    = game_pkg::BALL_H,
  parameter int BALL_W    = game_pkg::BALL_W,
  parameter int NET_X     = game_pkg::NET_X,
  parameter int NET_W     = game_pkg::NET_W
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_btn,
  input  logic [11:0] Ball_X,
  input  logic [11:0] Ball_Y,
  output logic [1:0]  Game_state,
  output logic        who_win,
  output logic [3:0]  player_score,
  output logic [3:0]  npc_score,
  output logic        point_pulse
);

  import game_pkg::*;

  localparam int              CNT_W     = (DROP_WAIT > 1) ? $clog2(DROP_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(DROP_WAIT - 1);
  localparam logic [3:0]      WIN_VAL   = 4'(WIN_SCORE);

  if (WIN_SCORE < 1 || WIN_SCORE > 15) begin : g_bad_win_score
    $error("game_ctrl: WIN_SCORE must be in 1..15");
  end
  if (DROP_WAIT < 1) begin : g_bad_drop_wait
    $error("game_ctrl: DROP_WAIT must be at least 1");
  end

  game_state_t      state_reg;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic [3:0]       player_score_reg;
  logic [3:0]       npc_score_reg;
  logic             who_win_reg;
  logic             point_pulse_reg;

  logic             btn_rise;
  logic             ground_hit;
  logic             left_half;
  logic [3:0]       player_inc;
  logic [3:0]       npc_inc;

  rise_detect u_start_rise (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (start_btn),
    .rise    (btn_rise)
  );

  assign ground_hit = ball_grounded(Ball_Y, BALL_H, GROUND_Y);
  assign left_half  = lands_left(Ball_X, BALL_W, NET_X, NET_W);
  assign player_inc = player_score_reg + 4'd1;
  assign npc_inc    = npc_score_reg + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_START;
      wait_cnt_reg     <= '0;
      player_score_reg <= '0;
      npc_score_reg    <= '0;
      who_win_reg      <= 1'b0;
      point_pulse_reg  <= 1'b0;
    end else begin
      point_pulse_reg <= 1'b0;
      case (state_reg)
        ST_START: begin
          player_score_reg <= '0;
          npc_score_reg    <= '0;
          if (btn_rise) begin
            state_reg    <= ST_WAIT;
            wait_cnt_reg <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg <= ST_PLAY;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
          end
        end
        ST_PLAY: begin
          // Leaving PLAY on the scoring edge is what limits a rally to one point.
          if (ground_hit) begin
            point_pulse_reg <= 1'b1;
            wait_cnt_reg    <= WAIT_LOAD;
            if (left_half) begin
              player_score_reg <= player_inc;
              who_win_reg      <= 1'b0;
              state_reg        <= (player_inc == WIN_VAL) ? ST_END : ST_WAIT;
            end else begin
              npc_score_reg <= npc_inc;
              who_win_reg   <= 1'b1;
              state_reg     <= (npc_inc == WIN_VAL) ? ST_END : ST_WAIT;
            end
          end
        end
        ST_END: begin
          if (btn_rise) begin
            state_reg        <= ST_START;
            player_score_reg <= '0;
            npc_score_reg    <= '0;
            who_win_reg      <= 1'b0;
          end
        end
        default: state_reg <= ST_START;
      endcase
    end
  end

  assign Game_state   = state_reg;
  assign who_win      = who_win_reg;
  assign player_score = player_score_reg;
  assign npc_score    = npc_score_reg;
  assign point_pulse  = point_pulse_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: two instances (different WIN_SCORE) share
// stimulus and are compared every cycle against a rule-level match model.
module tb_game_ctrl;

  import game_pkg::*;

  localparam int DW    = 4;
  localparam int WIN_A = 5;
  localparam int WIN_B = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_btn = 1'b0;
  logic [11:0] Ball_X = 12'd100;
  logic [11:0] Ball_Y = 12'd50;

  logic [1:0] gs_a, gs_b;
  logic       ww_a, ww_b, pp_a, pp_b;
  logic [3:0] ps_a, ns_a, ps_b, ns_b;

  int  total = 0;
  int  bad = 0;
  bit  cmp_en = 1'b0;

  always #5 clk = ~clk;

  game_ctrl #(.WIN_SCORE(WIN_A), .DROP_WAIT(DW)) dut_a (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn),
    .Ball_X(Ball_X), .Ball_Y(Ball_Y),
    .Game_state(gs_a), .who_win(ww_a), .player_score(ps_a),
    .npc_score(ns_a), .point_pulse(pp_a)
  );

  game_ctrl #(.WIN_SCORE(WIN_B), .DROP_WAIT(DW)) dut_b (
    .clk(clk), .reset_n(reset_n), .start_btn(start_btn),
    .Ball_X(Ball_X), .Ball_Y(Ball_Y),
    .Game_state(gs_b), .who_win(ww_b), .player_score(ps_b),
    .npc_score(ns_b), .point_pulse(pp_b)
  );

  // Match model: phase number, cycles of serve delay left, scores, last winner.
  typedef struct {
    int phase;
    int wait_left;
    int ps;
    int ns;
    int ww;
    int pulse;
  } mstate_t;

  mstate_t m [2];
  bit      m_prev;

  function automatic mstate_t step(mstate_t s, bit rise, int bx, int by, int win);
    mstate_t n;
    n = s;
    n.pulse = 0;
    case (s.phase)
      0: begin
        n.ps = 0;
        n.ns = 0;
        if (rise) begin
          n.phase = 1;
          n.wait_left = DW;
        end
      end
      1: begin
        n.wait_left = s.wait_left - 1;
        if (n.wait_left == 0) n.phase = 2;
      end
      2: begin
        if (by + BALL_H >= GROUND_Y) begin
          n.pulse = 1;
          if (bx + BALL_W / 2 < NET_X + NET_W / 2) begin
            n.ps = s.ps + 1;
            n.ww = 0;
          end else begin
            n.ns = s.ns + 1;
            n.ww = 1;
          end
          n.phase = (n.ps == win || n.ns == win) ? 3 : 1;
          n.wait_left = DW;
        end
      end
      default: begin
        if (rise) begin
          n.phase = 0;
          n.ps = 0;
          n.ns = 0;
          n.ww = 0;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
      m_prev <= 1'b0;
    end else begin
      m[0] <= step(m[0], start_btn && !m_prev, int'(Ball_X), int'(Ball_Y), WIN_A);
      m[1] <= step(m[1], start_btn && !m_prev, int'(Ball_X), int'(Ball_Y), WIN_B);
      m_prev <= start_btn;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_state", int'(gs_a), m[0].phase);
      chk("a_player", int'(ps_a), m[0].ps);
      chk("a_npc", int'(ns_a), m[0].ns);
      chk("a_who_win", int'(ww_a), m[0].ww);
      chk("a_pulse", int'(pp_a), m[0].pulse);
      chk("b_state", int'(gs_b), m[1].phase);
      chk("b_player", int'(ps_b), m[1].ps);
      chk("b_npc", int'(ns_b), m[1].ns);
      chk("b_who_win", int'(ww_b), m[1].ww);
      chk("b_pulse", int'(pp_b), m[1].pulse);
    end
  end

  task automatic air();
    Ball_X = 12'd100;
    Ball_Y = 12'd50;
  endtask

  task automatic wait_a(input int s);
    for (int k = 0; k < 50 && int'(gs_a) != s; k++) @(negedge clk);
    chk("wait_state_a", int'(gs_a), s);
  endtask

  task automatic hit(input int x, input int y);
    Ball_X = 12'(x);
    Ball_Y = 12'(y);
    @(negedge clk);
    air();
    $display("rally: x=%0d y=%0d -> a_state=%0d p=%0d n=%0d who=%0d", x, y, gs_a, ps_a, ns_a, ww_a);
  endtask

  task automatic press();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
  endtask

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    int pulses;
    bit rally_over;

    air();
    repeat (3) @(negedge clk);
    chk("rst_a_state", int'(gs_a), 0);
    chk("rst_a_player", int'(ps_a), 0);
    chk("rst_a_npc", int'(ns_a), 0);
    chk("rst_a_who_win", int'(ww_a), 0);
    chk("rst_a_pulse", int'(pp_a), 0);
    chk("rst_b_state", int'(gs_b), 0);
    reset_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // Start press, serve delay length
    press();
    chk("press_to_wait", int'(gs_a), 1);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gs_a != 2'd1) break;
      n++;
    end
    chk("wait_len", n, DW);
    chk("wait_to_play", int'(gs_a), 2);
    $display("serve: wait cycles=%0d", n);

    // Player point on the NPC half
    hit(60, 190);
    chk("p1_player", int'(ps_a), 1);
    chk("p1_who_win", int'(ww_a), 0);
    chk("p1_pulse", int'(pp_a), 1);
    chk("p1_state", int'(gs_a), 1);
    @(negedge clk);
    chk("p1_pulse_drop", int'(pp_a), 0);

    // Centre exactly on the split goes to the NPC
    wait_a(2);
    hit(148, 195);
    chk("split_npc", int'(ns_a), 1);
    chk("split_who_win", int'(ww_a), 1);
    chk("split_pulse", int'(pp_a), 1);

    // Ball held on the ground: one point for the rally
    wait_a(2);
    pulses = 0;
    rally_over = 1'b0;
    for (int k = 0; k < 10; k++) begin
      Ball_X = 12'd200;
      Ball_Y = rally_over ? 12'd50 : 12'd200;
      @(negedge clk);
      if (gs_a != 2'd2) rally_over = 1'b1;
      pulses += int'(pp_a);
    end
    air();
    chk("hold_one_point", pulses, 1);
    chk("hold_npc", int'(ns_a), 2);
    $display("hold: pulses=%0d npc=%0d", pulses, ns_a);

    // Instance B reached its target: END, frozen while A keeps playing
    chk("b_end_state", int'(gs_b), 3);
    chk("b_end_npc", int'(ns_b), 2);
    wait_a(2);
    hit(20, 200);
    chk("a_more_player", int'(ps_a), 2);
    chk("b_frozen_player", int'(ps_b), 1);
    chk("b_frozen_npc", int'(ns_b), 2);
    chk("b_frozen_state", int'(gs_b), 3);

    // Rise in END clears B; the same rise during A's WAIT is discarded
    press();
    chk("b_restart_state", int'(gs_b), 0);
    chk("b_restart_player", int'(ps_b), 0);
    chk("b_restart_npc", int'(ns_b), 0);
    chk("b_restart_who_win", int'(ww_b), 0);
    chk("a_ignores_rise", int'(gs_a), 1);
    @(negedge clk);
    press();
    chk("b_second_rise", int'(gs_b), 1);
    $display("restart: b_state=%0d", gs_b);

    // Randomised play, buttons and near-boundary landings
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
      if (gs_a == 2'd2 && $urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 4))
          0: Ball_X = 12'd147;
          1: Ball_X = 12'd148;
          2: Ball_X = 12'd149;
          3: Ball_X = 12'd4090;
          default: Ball_X = 12'($urandom_range(0, 319));
        endcase
        if ($urandom_range(0, 7) == 0) Ball_Y = 12'd4090;
        else Ball_Y = 12'($urandom_range(189, 240));
      end else begin
        Ball_X = 12'($urandom_range(0, 319));
        Ball_Y = 12'($urandom_range(0, 189));
      end
      @(negedge clk);
    end
    air();
    $display("random: a_state=%0d p=%0d n=%0d", gs_a, ps_a, ns_a);

    // Held button, then async reset mid-WAIT
    start_btn = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_btn = 1'b1;
    @(negedge clk);
    chk("held_to_wait", int'(gs_a), 1);
    wait_a(2);
    repeat (3) @(negedge clk);
    chk("held_no_extra", int'(gs_a), 2);
    hit(200, 200);
    chk("held_npc_point", int'(ns_a), 1);
    chk("held_back_wait", int'(gs_a), 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_a_state", int'(gs_a), 0);
    chk("async_a_npc", int'(ns_a), 0);
    chk("async_a_who_win", int'(ww_a), 0);
    chk("async_a_player", int'(ps_a), 0);
    chk("async_a_pulse", int'(pp_a), 0);
    chk("async_b_state", int'(gs_b), 0);
    $display("async reset: a_state=%0d", gs_a);
    start_btn = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_start", int'(gs_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
